// File: rtl/instr_decode_flags.sv
// Instruction register, opcode/field decoder and ALU flags register feeding control_unit.
// Also tracks sticky illegal opcodes and the number of IR loads since reset.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_HALT
  } decoded_instruction_type;
endpackage

module instr_decode_flags
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned RADDR_WIDTH = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ir_enable,
  input  logic [DATA_WIDTH-1:0]   instr_in,
  input  logic                    flags_reg_enable,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  input  logic                    alu_uov,
  input  logic                    alu_sov,
  output decoded_instruction_type decoded_instruction,
  output logic [RADDR_WIDTH-1:0]  a_addr,
  output logic [RADDR_WIDTH-1:0]  b_addr,
  output logic [RADDR_WIDTH-1:0]  c_addr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic                    illegal_op,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;
  logic                  uov_q, uov_d;
  logic                  sov_q, sov_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  unused_ir_bit;

  function automatic logic opcode_legal(input logic [7:0] op);
    unique case (op)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
      8'h81, 8'h82, 8'h83, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF: opcode_legal = 1'b1;
      default:                                                opcode_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    ir_d      = ir_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    if (ir_enable) begin
      ir_d    = instr_in;
      count_d = count_q + CNT_WIDTH'(1);
      // Flag the opcode at the same edge it enters the IR.
      if (!opcode_legal(instr_in[15:8])) illegal_d = 1'b1;
    end
  end

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    uov_d  = uov_q;
    sov_d  = sov_q;
    if (flags_reg_enable) begin
      zero_d = alu_zero;
      neg_d  = alu_neg;
      uov_d  = alu_uov;
      sov_d  = alu_sov;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      uov_q     <= 1'b0;
      sov_q     <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      ir_q      <= ir_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      uov_q     <= uov_d;
      sov_q     <= sov_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    decoded_instruction = I_NOP;
    a_addr              = '0;
    b_addr              = '0;
    c_addr              = '0;
    mem_addr            = '0;
    unique case (ir_q[15:8])
      8'h01: decoded_instruction = I_BRANCH;
      8'h02: decoded_instruction = I_BZERO;
      8'h03: decoded_instruction = I_BNZERO;
      8'h04: decoded_instruction = I_BNEG;
      8'h05: decoded_instruction = I_BNNEG;
      8'h06: decoded_instruction = I_BOV;
      8'h07: decoded_instruction = I_BNOV;
      8'h81: decoded_instruction = I_LOAD;
      8'h82: decoded_instruction = I_STORE;
      8'h83: decoded_instruction = I_MOVE;
      8'hA1: decoded_instruction = I_ADD;
      8'hA2: decoded_instruction = I_SUB;
      8'hA3: decoded_instruction = I_AND;
      8'hA4: decoded_instruction = I_OR;
      8'hFF: decoded_instruction = I_HALT;
      default: decoded_instruction = I_NOP;
    endcase

    case (decoded_instruction)
      I_ADD, I_SUB, I_AND, I_OR: begin
        c_addr = ir_q[5:4];
        a_addr = ir_q[3:2];
        b_addr = ir_q[1:0];
      end
      I_MOVE: begin
        c_addr = ir_q[3:2];
        a_addr = ir_q[1:0];
      end
      I_LOAD: begin
        c_addr   = ir_q[6:5];
        mem_addr = ir_q[ADDR_WIDTH-1:0];
      end
      I_STORE: begin
        a_addr   = ir_q[6:5];
        mem_addr = ir_q[ADDR_WIDTH-1:0];
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        mem_addr = ir_q[ADDR_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign unused_ir_bit     = ir_q[7];
  assign zero_op           = zero_q;
  assign neg_op            = neg_q;
  assign unsigned_overflow = uov_q;
  assign signed_overflow   = sov_q;
  assign illegal_op        = illegal_q;
  assign instr_count       = count_q;

endmodule
